// File: rtl/instr_fetch_buffer_if.sv
// Fetch-side bus bundle: PC in, stall out, instruction-memory request/response, decode handoff.
// slave = the fetch buffer, master = the surrounding PC / memory / decode environment.
interface instr_fetch_buffer_if;
  logic [31:0] iPC;
  logic        iFlush;
  logic        oStall;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemGnt;
  logic        iMemRValid;
  logic [31:0] iMemRData;
  logic        oInstValid;
  logic [31:0] oInst;
  logic [31:0] oInstPC;
  logic        iInstReady;

  modport slave (
    input  iPC, iFlush, iMemGnt, iMemRValid, iMemRData, iInstReady,
    output oStall, oMemReq, oMemAddr, oInstValid, oInst, oInstPC
  );

  modport master (
    output iPC, iFlush, iMemGnt, iMemRValid, iMemRData, iInstReady,
    input  oStall, oMemReq, oMemAddr, oInstValid, oInst, oInstPC
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Credit-limited instruction fetch buffer: issues PC fetches, pairs in-order responses with
// their PCs, drops stale responses after a flush. Define FETCH_BYPASS_EN for same-cycle bypass.
module instr_fetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               iClk,
  input  logic               iRst,
  instr_fetch_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [31:0]   aq_q   [MAX_OUTSTANDING];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_q, drop_d;

  logic credit_ok, mem_req, accept, rsp_valid, rsp_keep, fifo_empty, bypass, push, pop;

  function automatic logic [AW-1:0] aq_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + AW'(1);
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    credit_ok  = (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                 ((SW'(outstanding_q) + SW'(count_q)) < SW'(DEPTH));
    mem_req    = credit_ok && !bus.iFlush && !iRst;
    accept     = mem_req && bus.iMemGnt;
    rsp_valid  = bus.iMemRValid && (outstanding_q != '0);
    rsp_keep   = rsp_valid && (drop_q == '0) && !bus.iFlush;
    fifo_empty = (count_q == '0);
`ifdef FETCH_BYPASS_EN
    bypass     = fifo_empty && rsp_keep && bus.iInstReady && !iRst;
`else
    bypass     = 1'b0;
`endif
    push       = rsp_keep && !bypass;
    pop        = !fifo_empty && bus.iInstReady;

    bus.oMemReq    = mem_req;
    bus.oMemAddr   = bus.iPC;
    bus.oStall     = iRst || !(accept || bus.iFlush);
    bus.oInstValid = !iRst && (!fifo_empty || bypass);
    bus.oInst      = '0;
    bus.oInstPC    = '0;
    if (!fifo_empty) begin
      bus.oInst   = fifo_q[rd_ptr_q].inst;
      bus.oInstPC = fifo_q[rd_ptr_q].pc;
    end else if (bypass) begin
      bus.oInst   = bus.iMemRData;
      bus.oInstPC = aq_q[aq_rd_q];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !rsp_valid)      outstanding_d = outstanding_q + OW'(1);
    else if (!accept && rsp_valid) outstanding_d = outstanding_q - OW'(1);

    aq_wr_d = accept    ? aq_inc(aq_wr_q) : aq_wr_q;
    aq_rd_d = rsp_valid ? aq_inc(aq_rd_q) : aq_rd_q;

    // On a redirect every request still in flight, minus one answered now, belongs to the old path.
    drop_d = drop_q;
    if (bus.iFlush)                      drop_d = outstanding_q - OW'(rsp_valid);
    else if (rsp_valid && drop_q != '0)  drop_d = drop_q - OW'(1);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.iFlush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      aq_wr_q       <= '0;
      aq_rd_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      aq_wr_q       <= aq_wr_d;
      aq_rd_q       <= aq_rd_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers and counters alone define which entries are valid.
  always_ff @(posedge iClk) begin
    if (push)   fifo_q[wr_ptr_q] <= '{pc: aq_q[aq_rd_q], inst: bus.iMemRData};
    if (accept) aq_q[aq_wr_q]    <= bus.iPC;
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: queue-based reference model checked every cycle plus
// directed scenarios with hand-computed literal expectations (bypass-aware via FETCH_BYPASS_EN).
module tb_instr_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic iClk = 1'b0;
  logic iRst;
  instr_fetch_buffer_if bus();

  instr_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'hE000_0000 | a;
  endfunction

  // Reference model: pending request addresses, buffered {pc,inst} pairs, stale-response count.
  logic [31:0] m_out[$];
  logic [63:0] m_fifo[$];
  int          m_drop = 0;

  always @(negedge iClk) begin : model
    bit          credit, req, acc, rsp, byp;
    logic        e_valid;
    logic [31:0] e_inst, e_pc, a;
    credit = (m_out.size() < MAXO) && (m_out.size() + m_fifo.size() < DEPTH);
    req    = credit && !bus.iFlush && !iRst;
    acc    = req && bus.iMemGnt;
    rsp    = bus.iMemRValid && (m_out.size() > 0);
    byp    = BYP && rsp && (m_drop == 0) && (m_fifo.size() == 0) &&
             bus.iInstReady && !bus.iFlush && !iRst;
    e_pc   = '0;
    e_inst = '0;
    a      = '0;
    if (m_fifo.size() > 0) {e_pc, e_inst} = m_fifo[0];
    else if (byp) begin
      e_pc   = m_out[0];
      e_inst = bus.iMemRData;
    end
    e_valid = !iRst && ((m_fifo.size() > 0) || byp);

    check1("m_req",   bus.oMemReq, req);
    check1("m_stall", bus.oStall, iRst || !(acc || bus.iFlush));
    check ("m_addr",  bus.oMemAddr, bus.iPC);
    check1("m_valid", bus.oInstValid, e_valid);
    check ("m_inst",  bus.oInst, e_inst);
    check ("m_pc",    bus.oInstPC, e_pc);

    if (bus.iMemRValid && !iRst && m_out.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL protocol: response with no outstanding request at %0t", $time);
    end

    if (iRst) begin
      m_out.delete();
      m_fifo.delete();
      m_drop = 0;
    end else begin
      if (rsp) a = m_out.pop_front();
      if (bus.iFlush) begin
        m_drop = m_out.size();
        m_fifo.delete();
      end else begin
        if (m_fifo.size() > 0 && bus.iInstReady) void'(m_fifo.pop_front());
        if (rsp) begin
          if (m_drop > 0) m_drop--;
          else if (!byp) m_fifo.push_back({a, bus.iMemRData});
        end
      end
      if (acc) m_out.push_back(bus.iPC);
    end
  end

  task automatic drive(input logic rst, input logic [31:0] pc, input logic flush, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    iRst           = rst;
    bus.iPC        = pc;
    bus.iFlush     = flush;
    bus.iMemGnt    = gnt;
    bus.iMemRValid = rv;
    bus.iMemRData  = rd;
    bus.iInstReady = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    // Reset for two cycles
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h0, 0, 0, 0, 32'h0, 1);
      check1("rst_req", bus.oMemReq, 1'b0);
      check1("rst_stall", bus.oStall, 1'b1);
      check1("rst_valid", bus.oInstValid, 1'b0);
      tick();
    end

    // In-order fetch of PC 0,4,8 with single-cycle responses
    drive(0, 32'h0, 0, 1, 0, 32'h0, 1);
    check1("post_rst_req", bus.oMemReq, 1'b1);
    check ("post_rst_addr", bus.oMemAddr, 32'h0);
    check1("post_rst_stall", bus.oStall, 1'b0);
    tick();
    drive(0, 32'h4, 0, 1, 1, iw(32'h0), 1);
    check1("i0_valid", bus.oInstValid, BYP);
    tick();
    drive(0, 32'h8, 0, 1, 1, iw(32'h4), 1);
    check ("c_pc", bus.oInstPC, BYP ? 32'h4 : 32'h0);
    check ("c_inst", bus.oInst, BYP ? iw(32'h4) : iw(32'h0));
    tick();
    drive(0, 32'hC, 0, 0, 1, iw(32'h8), 1);
    check ("d_pc", bus.oInstPC, BYP ? 32'h8 : 32'h4);
    tick();
    drive(0, 32'hC, 0, 0, 0, 32'h0, 1);
    check1("e_valid", bus.oInstValid, !BYP);
    check ("e_pc", bus.oInstPC, BYP ? 32'h0 : 32'h8);
    tick();

    // Decode stalled: fill to DEPTH, then one pop admits exactly one request
    drive(0, 32'h40, 0, 1, 0, 32'h0, 0);        tick();
    drive(0, 32'h44, 0, 1, 1, iw(32'h40), 0);   tick();
    drive(0, 32'h48, 0, 1, 1, iw(32'h44), 0);   tick();
    drive(0, 32'h4C, 0, 1, 1, iw(32'h48), 0);   tick();
    drive(0, 32'h50, 0, 1, 1, iw(32'h4C), 0);
    check1("full_stall", bus.oStall, 1'b1);
    tick();
    drive(0, 32'h50, 0, 1, 0, 32'h0, 0);
    check1("full_req", bus.oMemReq, 1'b0);
    check ("full_head_pc", bus.oInstPC, 32'h40);
    tick();
    drive(0, 32'h50, 0, 1, 0, 32'h0, 1);
    check1("pop_cycle_stall", bus.oStall, 1'b1);
    tick();
    drive(0, 32'h50, 0, 1, 0, 32'h0, 0);
    check1("one_slot_stall", bus.oStall, 1'b0);
    check ("one_slot_addr", bus.oMemAddr, 32'h50);
    tick();
    drive(0, 32'h54, 0, 1, 0, 32'h0, 0);
    check1("refull_stall", bus.oStall, 1'b1);
    tick();
    drive(0, 32'h54, 0, 1, 1, iw(32'h50), 0);   tick();
    drive(0, 32'h54, 0, 0, 0, 32'h0, 1);
    check ("drain_head", bus.oInstPC, 32'h44);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h54, 0, 0, 0, 32'h0, 1);
      tick();
    end

    // Flush with two requests in flight
    drive(0, 32'h10, 0, 1, 0, 32'h0, 1);        tick();
    drive(0, 32'h14, 0, 1, 0, 32'h0, 1);        tick();
    drive(0, 32'h100, 1, 1, 0, 32'h0, 1);
    check1("flush_req", bus.oMemReq, 1'b0);
    check1("flush_stall", bus.oStall, 1'b0);
    tick();
    drive(0, 32'h100, 0, 1, 0, 32'h0, 1);
    check1("post_flush_valid", bus.oInstValid, 1'b0);
    check1("post_flush_stall", bus.oStall, 1'b1);
    tick();
    drive(0, 32'h100, 0, 1, 1, iw(32'h10), 1);
    check1("drop1_valid", bus.oInstValid, 1'b0);
    tick();
    drive(0, 32'h100, 0, 1, 1, iw(32'h14), 1);
    check1("drop2_stall", bus.oStall, 1'b0);
    check1("drop2_valid", bus.oInstValid, 1'b0);
    tick();
    drive(0, 32'h104, 0, 0, 1, iw(32'h100), 1);
    check ("redirect_pc_v", bus.oInstPC, BYP ? 32'h100 : 32'h0);
    tick();
    drive(0, 32'h104, 0, 0, 0, 32'h0, 1);
    check ("redirect_pc_w", bus.oInstPC, BYP ? 32'h0 : 32'h100);
    tick();

    // Flush coinciding with the response to the first in-flight request
    drive(0, 32'h10, 0, 1, 0, 32'h0, 1);        tick();
    drive(0, 32'h14, 0, 1, 0, 32'h0, 1);        tick();
    drive(0, 32'h200, 1, 1, 1, iw(32'h10), 1);
    check1("flush_rsp_valid", bus.oInstValid, 1'b0);
    tick();
    drive(0, 32'h200, 0, 0, 1, iw(32'h14), 1);
    check1("late_drop_valid", bus.oInstValid, 1'b0);
    tick();
    drive(0, 32'h200, 0, 1, 0, 32'h0, 1);
    check1("resume_req", bus.oMemReq, 1'b1);
    tick();
    drive(0, 32'h204, 0, 0, 1, iw(32'h200), 1);
    check1("resume_byp_valid", bus.oInstValid, BYP);
    tick();
    drive(0, 32'h204, 0, 0, 0, 32'h0, 1);
    check ("resume_pc", bus.oInstPC, BYP ? 32'h0 : 32'h200);
    tick();

    // Grant withheld for three cycles: PC held
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h20, 0, 0, 0, 32'h0, 1);
      check1("nogrant_stall", bus.oStall, 1'b1);
      check ("nogrant_addr", bus.oMemAddr, 32'h20);
      tick();
    end
    drive(0, 32'h20, 0, 1, 0, 32'h0, 1);
    check1("grant_stall", bus.oStall, 1'b0);
    tick();
    drive(0, 32'h24, 0, 0, 0, 32'h0, 1);
    check1("after_grant_stall", bus.oStall, 1'b1);
    tick();
    drive(0, 32'h24, 0, 0, 1, iw(32'h20), 1);   tick();
    drive(0, 32'h24, 0, 0, 0, 32'h0, 1);        tick();

    // Reset in the middle of operation
    drive(0, 32'h30, 0, 1, 0, 32'h0, 0);        tick();
    drive(0, 32'h34, 0, 1, 1, iw(32'h30), 0);   tick();
    drive(1, 32'h34, 0, 1, 0, 32'h0, 0);
    check1("mid_rst_valid", bus.oInstValid, 1'b0);
    check1("mid_rst_req", bus.oMemReq, 1'b0);
    check1("mid_rst_stall", bus.oStall, 1'b1);
    tick();
    drive(0, 32'h34, 0, 0, 0, 32'h0, 1);
    check1("post_mid_rst_valid", bus.oInstValid, 1'b0);
    check ("post_mid_rst_inst", bus.oInst, 32'h0);
    tick();
    drive(0, 32'h34, 0, 0, 0, 32'h0, 1);        tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
